thunderbird_taillight_ctrl: RTL and testbench
=============================================

THUNDERBIRD_TAILLIGHT_CTRL -- requirements
Module: thunderbird_taillight_ctrl

Interface
REQ-001 Parameter MAX_COUNT, default 1000, upper bound on the tick-divider period in clock cycles.
REQ-002 Parameter SYSTEM_FREQ, default 12500, clock frequency in Hz.
REQ-003 Parameter HZ, default 8, target sequencing step rate in Hz.
REQ-004 io_in[0] (clk), input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 io_in[1] (rst), input, 1 bit: reset, asynchronous and active-low.
REQ-006 io_in[2] (left), input, 1 bit: left-turn request.
REQ-007 io_in[3] (right), input, 1 bit: right-turn request.
REQ-008 io_in[4] (haz), input, 1 bit: hazard request.
REQ-009 io_in[7:5], input, 3 bits: unused, ignored.
REQ-010 io_out, output, 8 bits: [0]=RA, [1]=RB, [2]=RC (right lamps, inner to outer), [3]=LA, [4]=LB, [5]=LC (left lamps, inner to outer), [7:6] tied 0.

Function
REQ-011 Tick divider: PERIOD = min(SYSTEM_FREQ/HZ (integer division), MAX_COUNT); with the default parameters PERIOD = 1000.
REQ-012 Counter counts 0..PERIOD-1 and wraps to 0; a one-cycle tick asserts on the cycle the counter equals PERIOD-1.
REQ-013 left, right and haz pass through a 2-flop synchronizer before use.
REQ-014 The FSM advances only on tick; between ticks the state and io_out hold.
REQ-015 States and lamp outputs {LC,LB,LA,RA,RB,RC}:
- IDLE=000000
- L1=001000, L2=011000, L3=111000
- R1=000100, R2=000110, R3=000111
- HAZ=111111
REQ-016 From IDLE on tick, in priority order:
- haz=1, or left=1 and right=1: go to HAZ
- left=1 only: go to L1
- right=1 only: go to R1
- otherwise: stay in IDLE
REQ-017 On tick, L1->L2->L3->IDLE and R1->R2->R3->IDLE; each sequence completes even if its request drops mid-sequence.
REQ-018 On tick, if haz=1 in any L or R state, go to HAZ (haz preempts turn sequences).
REQ-019 On tick, HAZ always goes to IDLE; holding haz therefore flashes all six lamps on/off, one tick each.
REQ-020 After returning to IDLE, a still-asserted request restarts its sequence on the next tick (IDLE lasts one tick minimum).
REQ-021 io_out is registered from the state, with no combinational path from the inputs.

Reset
REQ-022 While rst=0, asynchronously: state=IDLE, counter=0, synchronizers=0, io_out=8'h00.
REQ-023 After rst rises, the first tick occurs PERIOD cycles later, when the counter reaches PERIOD-1.
REQ-024 Reset asserted mid-sequence returns to IDLE immediately; no partial lamp pattern persists.

Verification (default parameters, PERIOD=1000)
REQ-025 Reset 10 cycles, then release with all requests 0 -> io_out=00 for at least 5000 cycles.
REQ-026 left=1 held -> io_out steps 00, 08, 18, 38, 00, 08, … with one pattern per 1000 cycles.
REQ-027 right=1 held -> io_out steps 00, 01, 03, 07, 00, … with one pattern per 1000 cycles.
REQ-028 haz=1, or left=1 and right=1 together -> io_out alternates 3F and 00 every 1000 cycles.
REQ-029 left=1 until state L2, then haz=1 -> next tick io_out=3F, then 00, then 3F.
REQ-030 Pulse rst low while in R2 (io_out=03) -> io_out=00 immediately with no clock edge; sequence restarts only after rst=1 and a full PERIOD.

Source files
------------

// File: rtl/thunderbird_taillight_ctrl.sv
// Thunderbird-style sequential tail-light controller: a divided-down tick steps
// a small lamp FSM through left/right sweeps and a hazard flash.
module thunderbird_taillight_ctrl #(
  parameter int MAX_COUNT   = 1000,
  parameter int SYSTEM_FREQ = 12500,
  parameter int HZ          = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int RAW_PERIOD = SYSTEM_FREQ / HZ;
  localparam int MIN_PERIOD = (RAW_PERIOD < MAX_COUNT) ? RAW_PERIOD : MAX_COUNT;
  localparam int PERIOD     = (MIN_PERIOD < 1) ? 1 : MIN_PERIOD;
  localparam int CW         = ($clog2(PERIOD) < 1) ? 1 : $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;

  logic          clk;
  logic          rst_n;
  logic          unused_io;
  logic [CW-1:0] count;
  logic          tick;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic          left_s;
  logic          right_s;
  logic          haz_s;
  state_t        state;
  state_t        nxt;
  logic [5:0]    lamps;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign unused_io = &{1'b0, io_in[7:5]};

  // Lamp bits in io_out order: {LC, LB, LA, RC, RB, RA}.
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      L1:      lamps_of = 6'b001_000;
      L2:      lamps_of = 6'b011_000;
      L3:      lamps_of = 6'b111_000;
      R1:      lamps_of = 6'b000_001;
      R2:      lamps_of = 6'b000_011;
      R3:      lamps_of = 6'b000_111;
      HAZ:     lamps_of = 6'b111_111;
      default: lamps_of = 6'b000_000;
    endcase
  endfunction

  assign tick = (count == LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Two-flop synchronizer on {haz, right, left}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io_in[4:2];
      sync2 <= sync1;
    end
  end

  assign left_s  = sync2[0];
  assign right_s = sync2[1];
  assign haz_s   = sync2[2];

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    nxt = state;
    if (tick) begin
      case (state)
        IDLE: begin
          if (haz_s || (left_s && right_s)) nxt = HAZ;
          else if (left_s)                  nxt = L1;
          else if (right_s)                 nxt = R1;
          else                              nxt = IDLE;
        end
        L1:      nxt = haz_s ? HAZ : L2;
        L2:      nxt = haz_s ? HAZ : L3;
        L3:      nxt = haz_s ? HAZ : IDLE;
        R1:      nxt = haz_s ? HAZ : R2;
        R2:      nxt = haz_s ? HAZ : R3;
        R3:      nxt = haz_s ? HAZ : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Lamps are registered alongside the state so io_out never sees input glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lamps <= '0;
    end else begin
      state <= nxt;
      lamps <= lamps_of(nxt);
    end
  end

  assign io_out = {2'b00, lamps};

endmodule

// File: tb/tb_thunderbird_taillight_ctrl.sv
// Self-checking bench: directed lamp sequences plus random requests checked
// against a pattern-arithmetic reference model.
module tb_thunderbird_taillight_ctrl;

  localparam int PERIOD = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       haz = 1'b0;
  logic [2:0] junk = 3'b000;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] exp_out = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  assign io_in = {junk, haz, right, left, rst_n, clk};

  thunderbird_taillight_ctrl dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  // Next lamp pattern derived directly from the current pattern and requests.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input bit l, input bit r, input bit h);
    logic [2:0] lp;
    logic [2:0] rp;
    lp = cur[5:3];
    rp = cur[2:0];
    if (cur == 8'h3F) return 8'h00;
    if (cur == 8'h00) begin
      if (h || (l && r)) return 8'h3F;
      if (l) return 8'h08;
      if (r) return 8'h01;
      return 8'h00;
    end
    if (h) return 8'h3F;
    if (lp != 3'b000) return (lp == 3'b111) ? 8'h00 : {2'b00, 3'((lp << 1) | 3'b001), 3'b000};
    return (rp == 3'b111) ? 8'h00 : {5'b00000, 3'((rp << 1) | 3'b001)};
  endfunction

  // Entered just after a tick edge (or at reset release); checks hold, then the tick.
  task automatic tick_check(input string tag);
    logic [7:0] nxt;
    repeat (PERIOD - 1) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== exp_out) begin
      n_bad++;
      $display("FAIL %s_hold: io_out=%02h expected=%02h at %0t", tag, io_out, exp_out, $time);
    end
    nxt = model_next(exp_out, left, right, haz);
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== nxt) begin
      n_bad++;
      $display("FAIL %s_tick: io_out=%02h expected=%02h at %0t", tag, io_out, nxt, $time);
    end
    exp_out = nxt;
  endtask

  task automatic tick_lit(input string tag, input logic [7:0] lit);
    tick_check(tag);
    n_cmp++;
    if (io_out !== lit) begin
      n_bad++;
      $display("FAIL %s_lit: io_out=%02h expected=%02h at %0t", tag, io_out, lit, $time);
    end
  endtask

  task automatic drain();
    left  = 1'b0;
    right = 1'b0;
    haz   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_out != 8'h00) tick_check("drain");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: io_out=%02h expected=00", io_out);
    end
    rst_n = 1'b1;
    exp_out = 8'h00;
    for (int i = 0; i < 5; i++) tick_lit("idle", 8'h00);
  endtask

  task automatic test_left();
    logic [7:0] seq [5] = '{8'h08, 8'h18, 8'h38, 8'h00, 8'h08};
    drain();
    left = 1'b1;
    for (int i = 0; i < 5; i++) tick_lit("left", seq[i]);
    left = 1'b0;
    drain();
  endtask

  task automatic test_right();
    logic [7:0] seq [4] = '{8'h01, 8'h03, 8'h07, 8'h00};
    drain();
    right = 1'b1;
    for (int i = 0; i < 4; i++) tick_lit("right", seq[i]);
    right = 1'b0;
  endtask

  task automatic test_haz();
    logic [7:0] seq [4] = '{8'h3F, 8'h00, 8'h3F, 8'h00};
    drain();
    haz = 1'b1;
    for (int i = 0; i < 4; i++) tick_lit("haz", seq[i]);
    haz = 1'b0;
  endtask

  task automatic test_both();
    logic [7:0] seq [4] = '{8'h3F, 8'h00, 8'h3F, 8'h00};
    drain();
    left  = 1'b1;
    right = 1'b1;
    for (int i = 0; i < 4; i++) tick_lit("both", seq[i]);
    drain();
  endtask

  task automatic test_preempt();
    logic [7:0] seq [3] = '{8'h3F, 8'h00, 8'h3F};
    drain();
    left = 1'b1;
    tick_lit("pre_l1", 8'h08);
    tick_lit("pre_l2", 8'h18);
    left = 1'b0;
    haz  = 1'b1;
    for (int i = 0; i < 3; i++) tick_lit("preempt", seq[i]);
    drain();
  endtask

  task automatic test_reset_mid();
    drain();
    right = 1'b1;
    tick_lit("rst_r1", 8'h01);
    tick_lit("rst_r2", 8'h03);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset: io_out=%02h expected=00 at %0t", io_out, $time);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_out = 8'h00;
    tick_lit("restart", 8'h01);
    right = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      left  = 1'($urandom_range(0, 1));
      right = 1'($urandom_range(0, 1));
      haz   = ($urandom_range(0, 3) == 0);
      junk  = 3'($urandom);
      tick_check("random");
    end
    junk = 3'b000;
    drain();
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_haz();
    test_both();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
